// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 5..NB_DATA data bits, none/even/odd parity,
// 1 or 2 stop bits, 3-sample majority vote, break and framing detection.
module uart_rx_cfg #(
   parameter int NB_DATA = 8,
   parameter int OVS     = 16
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_rx,
   input  logic               i_tick,
   input  logic [3:0]         i_cfg_nbits,
   input  logic [1:0]         i_cfg_parity,
   input  logic               i_cfg_stop2,
   output logic               o_rxdone,
   output logic [NB_DATA-1:0] o_dout,
   output logic               o_parity_err,
   output logic               o_frame_err,
   output logic               o_break
);

   localparam int NB_CNT = $clog2(OVS);
   localparam logic [NB_CNT-1:0] C_S0   = NB_CNT'(OVS/2-1);
   localparam logic [NB_CNT-1:0] C_S1   = NB_CNT'(OVS/2);
   localparam logic [NB_CNT-1:0] C_DEC  = NB_CNT'(OVS/2+1);
   localparam logic [NB_CNT-1:0] C_LAST = NB_CNT'(OVS-1);
   localparam logic [3:0]        C_NBD  = 4'(NB_DATA);

   typedef enum logic [2:0] {
      IDLE, START, DATA, PARITY, STOP, WAIT_IDLE
   } state_t;

   state_t               r_state;
   state_t               w_next;
   logic [1:0]           r_sync;
   logic [NB_CNT-1:0]    r_cnt;
   logic                 r_s0;
   logic                 r_s1;
   logic [3:0]           r_bitidx;
   logic [3:0]           r_nbits;
   logic [1:0]           r_par;
   logic                 r_stop2;
   logic                 r_stopidx;
   logic [NB_DATA-1:0]   r_shift;
   logic                 r_parbit;
   logic                 r_perr_pend;
   logic                 r_ferr_pend;
   logic                 r_stop1;

   logic                 w_rx;
   logic                 w_dec;
   logic                 w_last;
   logic                 w_vote;
   logic                 w_par_en;
   logic                 w_last_bit;
   logic                 w_stop_final;
   logic                 w_done;
   logic                 w_ferr;
   logic                 w_first_stop;
   logic                 w_brk;
   logic [3:0]           w_nbits;

   assign w_rx         = r_sync[1];
   assign w_dec        = i_tick && (r_cnt == C_DEC);
   assign w_last       = i_tick && (r_cnt == C_LAST);
   assign w_vote       = (r_s0 & r_s1) | (r_s0 & w_rx) | (r_s1 & w_rx);
   assign w_par_en     = (r_par == 2'b01) || (r_par == 2'b10);
   assign w_last_bit   = (r_bitidx == r_nbits - 4'd1);
   assign w_stop_final = !r_stop2 || r_stopidx;
   assign w_done       = (r_state == STOP) && w_dec && w_stop_final;
   assign w_ferr       = r_ferr_pend | ~w_vote;
   assign w_first_stop = r_stop2 ? r_stop1 : w_vote;
   assign w_brk        = (r_shift == '0) && (!w_par_en || !r_parbit)
                         && !w_first_stop;
   assign w_nbits      = (i_cfg_nbits < 4'd5)  ? 4'd5  :
                         (i_cfg_nbits > C_NBD) ? C_NBD : i_cfg_nbits;

   // State register
   always_ff @(posedge i_clk) begin
      if (i_reset) r_state <= IDLE;
      else         r_state <= w_next;
   end

   // Next-state decode
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE:      if (!w_rx) w_next = START;
         START: begin
            if (w_dec && w_vote) w_next = IDLE;
            else if (w_last)     w_next = DATA;
         end
         DATA:      if (w_last && w_last_bit)
                       w_next = w_par_en ? PARITY : STOP;
         PARITY:    if (w_last) w_next = STOP;
         STOP:      if (w_done) w_next = w_ferr ? WAIT_IDLE : IDLE;
         WAIT_IDLE: if (w_rx) w_next = IDLE;
         default:   w_next = IDLE;
      endcase
   end

   // Synchronizer, tick counter, sampling, shift register and result outputs
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_sync       <= 2'b11;
         r_cnt        <= '0;
         r_s0         <= 1'b1;
         r_s1         <= 1'b1;
         r_bitidx     <= '0;
         r_nbits      <= 4'd5;
         r_par        <= '0;
         r_stop2      <= 1'b0;
         r_stopidx    <= 1'b0;
         r_shift      <= '0;
         r_parbit     <= 1'b0;
         r_perr_pend  <= 1'b0;
         r_ferr_pend  <= 1'b0;
         r_stop1      <= 1'b0;
         o_rxdone     <= 1'b0;
         o_dout       <= '0;
         o_parity_err <= 1'b0;
         o_frame_err  <= 1'b0;
         o_break      <= 1'b0;
      end else begin
         r_sync   <= {r_sync[0], i_rx};
         o_rxdone <= 1'b0;

         if (r_state == IDLE || w_next == IDLE || w_next == WAIT_IDLE)
            r_cnt <= '0;
         else if (i_tick)
            r_cnt <= (r_cnt == C_LAST) ? '0 : r_cnt + 1'b1;

         if (i_tick && r_cnt == C_S0) r_s0 <= w_rx;
         if (i_tick && r_cnt == C_S1) r_s1 <= w_rx;

         if (r_state == IDLE) begin
            r_bitidx  <= '0;
            r_stopidx <= 1'b0;
            if (!w_rx) begin
               r_nbits     <= w_nbits;
               r_par       <= i_cfg_parity;
               r_stop2     <= i_cfg_stop2;
               r_shift     <= '0;
               r_parbit    <= 1'b0;
               r_perr_pend <= 1'b0;
               r_ferr_pend <= 1'b0;
               r_stop1     <= 1'b0;
            end
         end

         if (r_state == DATA && w_dec)
            r_shift <= {w_vote, r_shift[NB_DATA-1:1]};
         if (r_state == DATA && w_last)
            r_bitidx <= w_last_bit ? '0 : r_bitidx + 4'd1;

         if (r_state == PARITY && w_dec) begin
            r_parbit    <= w_vote;
            r_perr_pend <= ^r_shift ^ w_vote ^ (r_par == 2'b10);
         end

         if (r_state == STOP && w_dec && !w_stop_final) begin
            r_stop1     <= w_vote;
            r_ferr_pend <= r_ferr_pend | ~w_vote;
         end
         if (r_state == STOP && w_last)
            r_stopidx <= 1'b1;

         if (w_done) begin
            o_rxdone     <= 1'b1;
            o_dout       <= r_shift >> (C_NBD - r_nbits);
            o_parity_err <= r_perr_pend;
            o_frame_err  <= w_ferr;
            o_break      <= w_brk;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: table of frames plus glitch, break and reset cases.
// Expected results are queued when a frame is driven and checked on o_rxdone.
module tb_uart_rx_cfg;

   localparam int NB  = 8;
   localparam int OVS = 16;

   typedef struct {
      logic [3:0] nb;
      logic [1:0] par;
      logic       st2;
      logic [7:0] data;
      logic       pbit;
      logic       s1;
      logic       s2;
      logic [7:0] e_dout;
      logic       e_perr;
      logic       e_ferr;
      logic       e_brk;
   } vec_t;

   typedef struct {
      logic [7:0] dout;
      logic       perr;
      logic       ferr;
      logic       brk;
   } exp_t;

   logic          i_clk = 1'b0;
   logic          i_reset = 1'b1;
   logic          i_rx = 1'b1;
   logic          i_tick = 1'b0;
   logic [3:0]    i_cfg_nbits = 4'd8;
   logic [1:0]    i_cfg_parity = 2'b00;
   logic          i_cfg_stop2 = 1'b0;
   logic          o_rxdone;
   logic [NB-1:0] o_dout;
   logic          o_parity_err;
   logic          o_frame_err;
   logic          o_break;

   int   checks = 0;
   int   errors = 0;
   int   n_done = 0;
   int   tcount = 0;
   int   done_tick = 0;
   int   stop_t0 = 0;
   logic [1:0] div = 2'd0;
   exp_t q[$];
   vec_t tbl[10];

   uart_rx_cfg #(.NB_DATA(NB), .OVS(OVS)) dut (
      .i_clk       (i_clk),
      .i_reset     (i_reset),
      .i_rx        (i_rx),
      .i_tick      (i_tick),
      .i_cfg_nbits (i_cfg_nbits),
      .i_cfg_parity(i_cfg_parity),
      .i_cfg_stop2 (i_cfg_stop2),
      .o_rxdone    (o_rxdone),
      .o_dout      (o_dout),
      .o_parity_err(o_parity_err),
      .o_frame_err (o_frame_err),
      .o_break     (o_break)
   );

   always #5 i_clk = ~i_clk;

   // Baud tick: one clock in four, changed on the falling edge
   always @(negedge i_clk) begin
      div = div + 2'd1;
      i_tick = (div == 2'd0);
   end

   always @(posedge i_clk) if (i_tick) tcount <= tcount + 1;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h", nm, act, exp);
      end
   endtask

   // Scoreboard: pop one expectation per completed frame
   always @(negedge i_clk) begin
      if (o_rxdone) begin
         exp_t e;
         n_done++;
         done_tick = tcount;
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rxdone got 1 want 0");
         end else begin
            e = q.pop_front();
            chk("dout", 32'(o_dout), 32'(e.dout));
            chk("parity_err", 32'(o_parity_err), 32'(e.perr));
            chk("frame_err", 32'(o_frame_err), 32'(e.ferr));
            chk("break", 32'(o_break), 32'(e.brk));
         end
      end
   end

   task automatic wait_ticks(input int n);
      int k = 0;
      while (k < n) begin
         @(posedge i_clk);
         if (i_tick) k++;
      end
      @(negedge i_clk);
   endtask

   task automatic send_bit(input logic b);
      i_rx = b;
      wait_ticks(OVS);
   endtask

   function automatic int eff_n(input logic [3:0] nb);
      if (nb < 4'd5) return 5;
      if (nb > 4'd8) return 8;
      return int'(nb);
   endfunction

   task automatic send_frame(input vec_t v);
      int n;
      n = eff_n(v.nb);
      i_cfg_nbits  = v.nb;
      i_cfg_parity = v.par;
      i_cfg_stop2  = v.st2;
      q.push_back('{v.e_dout, v.e_perr, v.e_ferr, v.e_brk});
      send_bit(1'b0);
      i_cfg_nbits  = 4'($urandom_range(0, 15));
      i_cfg_parity = 2'($urandom_range(0, 3));
      i_cfg_stop2  = 1'($urandom_range(0, 1));
      for (int i = 0; i < n; i++) send_bit(v.data[i]);
      if (v.par == 2'b01 || v.par == 2'b10) send_bit(v.pbit);
      if (v.st2) begin
         send_bit(v.s1);
         stop_t0 = tcount;
         send_bit(v.s2);
      end else begin
         stop_t0 = tcount;
         send_bit(v.s1);
      end
      i_rx = 1'b1;
      wait_ticks(2 * OVS);
      chk("frame_received", 32'(q.size()), 32'd0);
      chk("done_mid_stop",
          32'((done_tick - stop_t0 >= 9) && (done_tick - stop_t0 <= 12)),
          32'd1);
      q.delete();
   endtask

   initial begin
      vec_t v;
      int   n0;
      // nb par st2 data pbit s1 s2 | dout perr ferr brk
      tbl[0] = '{4'd8,  2'b00, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b1,
                 8'hA5, 1'b0, 1'b0, 1'b0};
      tbl[1] = '{4'd7,  2'b01, 1'b0, 8'h41, 1'b1, 1'b1, 1'b1,
                 8'h41, 1'b1, 1'b0, 1'b0};
      tbl[2] = '{4'd7,  2'b01, 1'b0, 8'h41, 1'b0, 1'b1, 1'b1,
                 8'h41, 1'b0, 1'b0, 1'b0};
      tbl[3] = '{4'd5,  2'b10, 1'b1, 8'h1F, 1'b0, 1'b1, 1'b0,
                 8'h1F, 1'b0, 1'b1, 1'b0};
      tbl[4] = '{4'd3,  2'b00, 1'b0, 8'h0B, 1'b0, 1'b1, 1'b1,
                 8'h0B, 1'b0, 1'b0, 1'b0};
      tbl[5] = '{4'd12, 2'b10, 1'b0, 8'hFF, 1'b1, 1'b1, 1'b1,
                 8'hFF, 1'b0, 1'b0, 1'b0};
      tbl[6] = '{4'd6,  2'b01, 1'b1, 8'h2A, 1'b1, 1'b1, 1'b1,
                 8'h2A, 1'b0, 1'b0, 1'b0};
      tbl[7] = '{4'd8,  2'b00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1,
                 8'h00, 1'b0, 1'b1, 1'b1};
      tbl[8] = '{4'd8,  2'b01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1,
                 8'h00, 1'b1, 1'b1, 1'b0};
      tbl[9] = '{4'd8,  2'b10, 1'b0, 8'h80, 1'b0, 1'b1, 1'b1,
                 8'h80, 1'b0, 1'b0, 1'b0};

      repeat (4) @(negedge i_clk);
      chk("rst_rxdone", 32'(o_rxdone), 32'd0);
      chk("rst_dout", 32'(o_dout), 32'd0);
      chk("rst_perr", 32'(o_parity_err), 32'd0);
      chk("rst_ferr", 32'(o_frame_err), 32'd0);
      chk("rst_brk", 32'(o_break), 32'd0);
      i_reset = 1'b0;
      wait_ticks(2 * OVS);

      for (int i = 0; i < 10; i++) send_frame(tbl[i]);

      // Short low glitch from idle is a false start
      n0 = n_done;
      i_rx = 1'b0;
      wait_ticks(5);
      i_rx = 1'b1;
      wait_ticks(3 * OVS);
      chk("glitch_no_done", 32'(n_done - n0), 32'd0);
      chk("glitch_dout_hold", 32'(o_dout), 32'h80);

      // Line held low for three frame times: a single break frame
      i_cfg_nbits  = 4'd8;
      i_cfg_parity = 2'b00;
      i_cfg_stop2  = 1'b0;
      n0 = n_done;
      q.push_back('{8'h00, 1'b0, 1'b1, 1'b1});
      i_rx = 1'b0;
      wait_ticks(3 * 10 * OVS);
      chk("hold_one_done", 32'(n_done - n0), 32'd1);
      chk("hold_q_empty", 32'(q.size()), 32'd0);
      q.delete();
      i_rx = 1'b1;
      wait_ticks(2 * OVS);
      v = '{4'd8, 2'b00, 1'b0, 8'h3C, 1'b0, 1'b1, 1'b1,
            8'h3C, 1'b0, 1'b0, 1'b0};
      send_frame(v);

      // Reset in the middle of data bit 4 aborts the frame
      n0 = n_done;
      v = '{4'd8, 2'b00, 1'b0, 8'h5A, 1'b0, 1'b1, 1'b1,
            8'h5A, 1'b0, 1'b0, 1'b0};
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(v.data[i]);
      i_rx = v.data[4];
      wait_ticks(8);
      i_reset = 1'b1;
      repeat (2) @(negedge i_clk);
      i_reset = 1'b0;
      @(negedge i_clk);
      chk("mid_rst_dout", 32'(o_dout), 32'd0);
      chk("mid_rst_perr", 32'(o_parity_err), 32'd0);
      chk("mid_rst_ferr", 32'(o_frame_err), 32'd0);
      chk("mid_rst_brk", 32'(o_break), 32'd0);
      i_rx = 1'b1;
      wait_ticks(3 * OVS);
      chk("mid_rst_no_done", 32'(n_done - n0), 32'd0);
      send_frame(v);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
